lcd_char_refresh: RTL and testbench
===================================

Name: lcd_char_refresh

Overview:
- Reader/display end of the 32-character LCD text buffer that the binary-to-decimal formatter fills through its dat/addr/we write port.
- Initialises an HD44780-compatible 2x16 character LCD over its 8-bit parallel bus.
- On request, reads all 32 buffer bytes through a synchronous read port and writes them to the display: addresses 0-15 go to line 1, 16-31 to line 2.

Parameters:
- POWERUP_CYC, 1000000, clk cycles to wait after reset release before the first command (20 ms at 50 MHz).
- T_AS_CYC, 2, cycles RS/DB are stable with E low before E rises (min 1).
- T_PW_CYC, 25, cycles E is held high (min 1).
- CMD_WAIT_CYC, 2500, cycles after E falls before the next write.
- CLR_WAIT_CYC, 100000, post-E wait used only after command 0x01.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- refresh_req  in  1  single-cycle request to redraw the display
- rd_addr  out  5  buffer read address
- rd_data  in  8  buffer byte, valid one cycle after rd_addr is sampled by the RAM (synchronous read)
- lcd_rs  out  1  0 = command, 1 = data
- lcd_rw  out  1  tied to 0, write-only
- lcd_e  out  1  enable strobe
- lcd_db  out  8  LCD data bus
- init_done  out  1  high once the init sequence has completed
- busy  out  1  high whenever not in IDLE
- frame_done  out  1  one-cycle pulse after the last character write of a frame completes its wait

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- All outputs are registered. Wait counter is 24 bits; every parameter must be < 2^24.
- Reset values: lcd_e 0, lcd_rs 0, lcd_rw 0, lcd_db 0x00, rd_addr 0, init_done 0, busy 1, frame_done 0, pending 0, state POWERUP.
- Reset asserted mid-operation: all outputs go to reset values immediately (E drops at once), and the sequence restarts from POWERUP.
- Write primitive (shared by commands and data):
  - SETUP: drive lcd_rs/lcd_db with lcd_e=0 for T_AS_CYC cycles.
  - EHIGH: lcd_e=1 for T_PW_CYC cycles.
  - WAIT: lcd_e=0 for CMD_WAIT_CYC cycles, or CLR_WAIT_CYC if the byte was command 0x01.
  - lcd_rs/lcd_db hold their values through WAIT.
  - Total per write = T_AS_CYC + T_PW_CYC + wait.
- States:
  - POWERUP: count POWERUP_CYC cycles, then go to INIT.
  - INIT: command sequence 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 (rs=0), each via the write primitive. After the last WAIT, set init_done=1 and go to IDLE.
  - IDLE: busy=0. If pending, clear pending, set busy=1 and go to LINE1.
  - LINE1: command 0x80, then idx=0.
  - FETCH_A: rd_addr<=idx, 1 cycle.
  - FETCH_D: 1 cycle; at its end latch lcd_db<=rd_data and lcd_rs<=1. Bytes pass through unmodified (0xF2 etc. are legal glyphs).
  - Data write via the write primitive, then:
    - idx==15: go to LINE2 (command 0xC0), then idx=16.
    - idx==31: pulse frame_done for 1 cycle, go to IDLE.
    - otherwise: idx+1, back to FETCH_A.
- refresh_req handling:
  - Any cycle: set pending, including during POWERUP/INIT and mid-frame.
  - Requests are never queued beyond one (sticky flag).
  - A request arriving mid-frame or on the frame_done cycle causes exactly one more frame after the current one.
  - IDLE with pending set leaves on the next cycle; refresh latency from IDLE = 1 cycle to LINE1 SETUP start.
- lcd_rw is constant 0; the busy flag is never read (timing-based only).

Test Plan:
1. POWERUP_CYC=20, T_AS=1, T_PW=3, CMD_WAIT=5, CLR_WAIT=12; release rst_n -> first lcd_e rise at cycle 21. Six init pulses with DB 38,38,38,0C,01,06, rs=0. Gap after the 01 pulse is 12 cycles, others 5. init_done rises after the 06 wait.
2. Buffer preloaded with "R: ...." bytes 0x20-0x39, single refresh_req after init -> 34 E pulses: 0x80(rs0), bytes 0-15(rs1), 0xC0(rs0), bytes 16-31(rs1). rd_addr is 0..31 in order; frame_done pulses once; busy returns to 0.
3. Buffer byte 5 = 0xF2 and byte 31 = 0x00 -> written verbatim as 0xF2 and 0x00.
4. refresh_req pulsed during INIT and twice more mid-frame -> exactly two frames total, back-to-back with no IDLE dwell beyond 1 cycle.
5. rst_n asserted while lcd_e=1 during char 20 -> lcd_e=0 and init_done=0 immediately. After release, full POWERUP+INIT repeats; the pending request was cleared.
6. Measure E high width = T_PW cycles and RS/DB stable T_AS cycles before E rise and throughout WAIT, for every write in scenario 2.

Source files
------------

// File: rtl/lcd_char_refresh_if.sv
// Buffer read port and HD44780 parallel bus of the LCD refresh engine.
//   master : the refresh engine (drives rd_addr and the LCD pins, reads rd_data)
//   slave  : the text buffer RAM and LCD side
//   rd_addr[4:0]  buffer read address
//   rd_data[7:0]  buffer byte, one cycle after rd_addr is sampled
//   lcd_rs        0 = command, 1 = data
//   lcd_rw        always 0 (write-only bus)
//   lcd_e         enable strobe
//   lcd_db[7:0]   LCD data bus
interface lcd_char_refresh_if;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_db;

    modport master (
        output rd_addr, lcd_rs, lcd_rw, lcd_e, lcd_db,
        input  rd_data
    );

    modport slave (
        input  rd_addr, lcd_rs, lcd_rw, lcd_e, lcd_db,
        output rd_data
    );
endinterface

// File: rtl/lcd_char_refresh.sv
// Display end of the 32-character text buffer. After power-up it runs the
// HD44780 8-bit init sequence, then on each refresh request reads all 32
// buffer bytes (0-15 -> line 1, 16-31 -> line 2) and writes them to the LCD.
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   refresh_req  single-cycle redraw request (sticky, one deep)
//   bus          buffer read port + LCD bus (master side)
//   init_done    high once the init sequence has completed
//   busy         high whenever not idle
//   frame_done   one-cycle pulse after the last character write's wait
module lcd_char_refresh #(
    parameter int unsigned POWERUP_CYC  = 1000000,
    parameter int unsigned T_AS_CYC     = 2,
    parameter int unsigned T_PW_CYC     = 25,
    parameter int unsigned CMD_WAIT_CYC = 2500,
    parameter int unsigned CLR_WAIT_CYC = 100000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               refresh_req,
    lcd_char_refresh_if.master bus,
    output logic               init_done,
    output logic               busy,
    output logic               frame_done
);

    localparam logic [23:0] D_PWR = 24'(POWERUP_CYC);
    localparam logic [23:0] D_AS  = 24'(T_AS_CYC);
    localparam logic [23:0] D_PW  = 24'(T_PW_CYC);
    localparam logic [23:0] D_CMD = 24'(CMD_WAIT_CYC);
    localparam logic [23:0] D_CLR = 24'(CLR_WAIT_CYC);

    typedef enum logic [2:0] {
        S_POWERUP, S_SETUP, S_EHIGH, S_WAIT, S_IDLE, S_FETCH_A, S_FETCH_D
    } state_t;

    // What the current write primitive is transferring.
    typedef enum logic [1:0] {K_INIT, K_LINE1, K_DATA, K_LINE2} kind_t;

    state_t      state, state_n;
    kind_t       kind, kind_n;
    logic [4:0]  step, step_n;      // init command index or character index
    logic [23:0] cnt, dur;
    logic        done;
    logic        pending, pending_n;

    logic        lcd_rs_q, rs_n;
    logic        lcd_e_q, e_n;
    logic [7:0]  lcd_db_q, db_n;
    logic [4:0]  rd_addr_q, rd_addr_n;
    logic        init_done_n, busy_n, frame_done_n;

    function automatic logic [7:0] init_cmd(input logic [4:0] i);
        case (i)
            5'd0, 5'd1, 5'd2: init_cmd = 8'h38;
            5'd3:             init_cmd = 8'h0C;
            5'd4:             init_cmd = 8'h01;
            default:          init_cmd = 8'h06;
        endcase
    endfunction

    // Clear-display needs the long post-strobe wait; everything else the short one.
    always_comb begin
        case (state)
            S_POWERUP: dur = D_PWR;
            S_SETUP:   dur = D_AS;
            S_EHIGH:   dur = D_PW;
            S_WAIT:    dur = (!lcd_rs_q && lcd_db_q == 8'h01) ? D_CLR : D_CMD;
            default:   dur = 24'd1;
        endcase
        done = (cnt == dur - 24'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_POWERUP;
            kind       <= K_INIT;
            step       <= '0;
            cnt        <= '0;
            pending    <= 1'b0;
            lcd_rs_q   <= 1'b0;
            lcd_e_q    <= 1'b0;
            lcd_db_q   <= '0;
            rd_addr_q  <= '0;
            init_done  <= 1'b0;
            busy       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            kind       <= kind_n;
            step       <= step_n;
            cnt        <= (state_n != state) ? '0 : cnt + 24'd1;
            pending    <= pending_n;
            lcd_rs_q   <= rs_n;
            lcd_e_q    <= e_n;
            lcd_db_q   <= db_n;
            rd_addr_q  <= rd_addr_n;
            init_done  <= init_done_n;
            busy       <= busy_n;
            frame_done <= frame_done_n;
        end
    end

    always_comb begin
        state_n   = state;
        kind_n    = kind;
        step_n    = step;
        pending_n = refresh_req | (pending & (state != S_IDLE));
        case (state)
            S_POWERUP: if (done) begin
                state_n = S_SETUP;
                kind_n  = K_INIT;
                step_n  = '0;
            end
            S_SETUP: if (done) state_n = S_EHIGH;
            S_EHIGH: if (done) state_n = S_WAIT;
            S_WAIT: if (done) begin
                case (kind)
                    K_INIT: begin
                        if (step == 5'd5) begin
                            state_n = S_IDLE;
                        end else begin
                            state_n = S_SETUP;
                            step_n  = step + 5'd1;
                        end
                    end
                    K_LINE1: begin
                        state_n = S_FETCH_A;
                        kind_n  = K_DATA;
                        step_n  = 5'd0;
                    end
                    K_LINE2: begin
                        state_n = S_FETCH_A;
                        kind_n  = K_DATA;
                        step_n  = 5'd16;
                    end
                    default: begin
                        if (step == 5'd15) begin
                            state_n = S_SETUP;
                            kind_n  = K_LINE2;
                        end else if (step == 5'd31) begin
                            state_n = S_IDLE;
                        end else begin
                            state_n = S_FETCH_A;
                            step_n  = step + 5'd1;
                        end
                    end
                endcase
            end
            S_IDLE: if (pending) begin
                state_n = S_SETUP;
                kind_n  = K_LINE1;
            end
            S_FETCH_A: state_n = S_FETCH_D;
            S_FETCH_D: state_n = S_SETUP;
            default:   state_n = S_POWERUP;
        endcase
    end

    // Outputs are registered, so their next values are decoded from the
    // next state; RS/DB load only on entry to SETUP and hold until the next one.
    always_comb begin
        rs_n = lcd_rs_q;
        db_n = lcd_db_q;
        if (state_n == S_SETUP && state != S_SETUP) begin
            case (kind_n)
                K_INIT:  begin rs_n = 1'b0; db_n = init_cmd(step_n); end
                K_LINE1: begin rs_n = 1'b0; db_n = 8'h80;            end
                K_LINE2: begin rs_n = 1'b0; db_n = 8'hC0;            end
                default: begin rs_n = 1'b1; db_n = bus.rd_data;      end
            endcase
        end
        e_n          = (state_n == S_EHIGH);
        busy_n       = (state_n != S_IDLE);
        rd_addr_n    = (state_n == S_FETCH_A) ? step_n : rd_addr_q;
        init_done_n  = init_done |
                       (state == S_WAIT && done && kind == K_INIT && step == 5'd5);
        frame_done_n = (state == S_WAIT && done && kind == K_DATA && step == 5'd31);
    end

    assign bus.lcd_rs  = lcd_rs_q;
    assign bus.lcd_rw  = 1'b0;
    assign bus.lcd_e   = lcd_e_q;
    assign bus.lcd_db  = lcd_db_q;
    assign bus.rd_addr = rd_addr_q;

endmodule

// File: tb/tb_lcd_char_refresh.sv
module tb_lcd_char_refresh;

    localparam int unsigned P_PWR = 20;
    localparam int unsigned P_AS  = 1;
    localparam int unsigned P_PW  = 3;
    localparam int unsigned P_CMD = 5;
    localparam int unsigned P_CLR = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic refresh_req = 1'b0;
    logic init_done, busy, frame_done;

    lcd_char_refresh_if bus();

    lcd_char_refresh #(
        .POWERUP_CYC (P_PWR),
        .T_AS_CYC    (P_AS),
        .T_PW_CYC    (P_PW),
        .CMD_WAIT_CYC(P_CMD),
        .CLR_WAIT_CYC(P_CLR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .refresh_req(refresh_req),
        .bus        (bus),
        .init_done  (init_done),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Text buffer with synchronous read.
    logic [7:0] mem [32];
    always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    // Event logs gathered by the bus monitor.
    int unsigned rise_q[$], fall_q[$], chg_q[$], fd_q[$], id_q[$];
    logic        rs_q[$];
    logic [7:0]  db_q[$];
    logic [4:0]  addr_q[$];

    logic       prev_e = 1'b0, prev_rs = 1'b0, prev_id = 1'b0;
    logic [7:0] prev_db = 8'h00;

    always @(negedge clk) begin
        if (bus.lcd_rs !== prev_rs || bus.lcd_db !== prev_db) chg_q.push_back(cyc);
        if (bus.lcd_e === 1'b1 && !prev_e) begin
            rise_q.push_back(cyc);
            rs_q.push_back(bus.lcd_rs);
            db_q.push_back(bus.lcd_db);
            addr_q.push_back(bus.rd_addr);
        end
        if (bus.lcd_e !== 1'b1 && prev_e) fall_q.push_back(cyc);
        if (frame_done === 1'b1) fd_q.push_back(cyc);
        if (init_done === 1'b1 && !prev_id) id_q.push_back(cyc);
        prev_e  = (bus.lcd_e === 1'b1);
        prev_rs = bus.lcd_rs;
        prev_db = bus.lcd_db;
        prev_id = (init_done === 1'b1);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish within 1 ms");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] model_init_cmd(input int unsigned k);
        logic [7:0] seq [6];
        seq = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        return seq[k];
    endfunction

    function automatic int unsigned model_init_wait(input logic [7:0] cmd);
        return (cmd == 8'h01) ? P_CLR : P_CMD;
    endfunction

    // {rs, db} of pulse k within a frame.
    function automatic logic [8:0] model_frame(input int unsigned k);
        if (k == 0)  return {1'b0, 8'h80};
        if (k <= 16) return {1'b1, mem[5'(k - 1)]};
        if (k == 17) return {1'b0, 8'hC0};
        return {1'b1, mem[5'(k - 2)]};
    endfunction

    // Falling edge of pulse k-1 to rising edge of pulse k; data writes add the two fetch cycles.
    function automatic int unsigned model_frame_gap(input int unsigned k);
        logic [8:0] p;
        p = model_frame(k);
        return P_CMD + P_AS + (p[8] ? 2 : 0);
    endfunction

    function automatic logic [4:0] model_frame_addr(input int unsigned k);
        return (k <= 16) ? 5'(k - 1) : 5'(k - 2);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic clear_logs();
        rise_q.delete(); fall_q.delete(); chg_q.delete(); fd_q.delete(); id_q.delete();
        rs_q.delete(); db_q.delete(); addr_q.delete();
    endtask

    task automatic release_reset(output int unsigned rel);
        @(posedge clk);
        #2;
        clear_logs();
        rst_n = 1'b1;
        rel = cyc;
    endtask

    task automatic pulse_req();
        @(posedge clk);
        #1 refresh_req = 1'b1;
        @(posedge clk);
        #1 refresh_req = 1'b0;
    endtask

    task automatic wait_rises(input int unsigned n, input int unsigned budget);
        for (int unsigned i = 0; i < budget; i++) begin
            if (rise_q.size() >= n) break;
            @(posedge clk);
        end
    endtask

    task automatic wait_frames(input int unsigned n, input int unsigned budget);
        for (int unsigned i = 0; i < budget; i++) begin
            if (fd_q.size() >= n) break;
            @(posedge clk);
        end
    endtask

    task automatic wait_init(input int unsigned budget);
        for (int unsigned i = 0; i < budget; i++) begin
            if (id_q.size() >= 1) break;
            @(posedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nvec++; if (bus.lcd_e !== 1'b0)    begin nerr++; $display("FAIL reset_e: got %b want 0", bus.lcd_e); end
        nvec++; if (bus.lcd_rs !== 1'b0)   begin nerr++; $display("FAIL reset_rs: got %b want 0", bus.lcd_rs); end
        nvec++; if (bus.lcd_rw !== 1'b0)   begin nerr++; $display("FAIL reset_rw: got %b want 0", bus.lcd_rw); end
        nvec++; if (bus.lcd_db !== 8'h00)  begin nerr++; $display("FAIL reset_db: got %h want 00", bus.lcd_db); end
        nvec++; if (bus.rd_addr !== 5'd0)  begin nerr++; $display("FAIL reset_addr: got %0d want 0", bus.rd_addr); end
        nvec++; if (init_done !== 1'b0)    begin nerr++; $display("FAIL reset_init_done: got %b want 0", init_done); end
        nvec++; if (busy !== 1'b1)         begin nerr++; $display("FAIL reset_busy: got %b want 1", busy); end
        nvec++; if (frame_done !== 1'b0)   begin nerr++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    endtask

    task automatic test_init();
        int unsigned rel, want;
        release_reset(rel);
        repeat (5) @(posedge clk);
        #1;
        nvec++; if (busy !== 1'b1 || bus.lcd_e !== 1'b0) begin nerr++; $display("FAIL powerup_idle: got busy=%b e=%b want busy=1 e=0", busy, bus.lcd_e); end
        wait_init(2000);
        @(negedge clk); #1;
        nvec++; if (id_q.size() != 1) begin nerr++; $display("FAIL init_done_seen: got %0d rises want 1", id_q.size()); end
        nvec++; if (rise_q.size() != 6 || fall_q.size() != 6) begin nerr++; $display("FAIL init_pulse_count: got %0d want 6", rise_q.size()); end
        if (rise_q.size() == 6 && fall_q.size() == 6 && id_q.size() == 1) begin
            want = rel + P_PWR + P_AS;
            nvec++; if (rise_q[0] != want) begin nerr++; $display("FAIL init_first_rise: got %0d want %0d", rise_q[0] - rel, want - rel); end
            for (int unsigned k = 0; k < 6; k++) begin
                nvec++; if (rs_q[k] !== 1'b0) begin nerr++; $display("FAIL init_rs[%0d]: got %b want 0", k, rs_q[k]); end
                nvec++; if (db_q[k] !== model_init_cmd(k)) begin nerr++; $display("FAIL init_db[%0d]: got %h want %h", k, db_q[k], model_init_cmd(k)); end
                nvec++; if (fall_q[k] - rise_q[k] != P_PW) begin nerr++; $display("FAIL init_ewidth[%0d]: got %0d want %0d", k, fall_q[k] - rise_q[k], P_PW); end
                if (k > 0) begin
                    want = model_init_wait(model_init_cmd(k - 1)) + P_AS;
                    nvec++; if (rise_q[k] - fall_q[k - 1] != want) begin nerr++; $display("FAIL init_gap[%0d]: got %0d want %0d", k, rise_q[k] - fall_q[k - 1], want); end
                end
            end
            nvec++; if (id_q[0] != fall_q[5] + P_CMD) begin nerr++; $display("FAIL init_done_time: got %0d want %0d", id_q[0] - fall_q[5], P_CMD); end
        end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL init_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_frame(input int unsigned mode);
        int unsigned t0, c_before, c_after, want;
        logic [8:0] e;
        logic       have_before, have_after;
        for (int unsigned i = 0; i < 32; i++) begin
            if (mode == 0) mem[i] = (i == 0) ? 8'h52 : (i == 1) ? 8'h3A : 8'(8'h20 + $urandom_range(0, 25));
            else           mem[i] = 8'($urandom_range(0, 255));
        end
        if (mode == 1) begin
            mem[5]  = 8'hF2;
            mem[31] = 8'h00;
        end
        clear_logs();
        @(posedge clk);
        #1 refresh_req = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1 refresh_req = 1'b0;
        wait_frames(1, 3000);
        repeat (30) @(posedge clk);
        #1;
        nvec++; if (fd_q.size() != 1) begin nerr++; $display("FAIL frame%0d_done_count: got %0d want 1", mode, fd_q.size()); end
        nvec++; if (rise_q.size() != 34 || fall_q.size() != 34) begin nerr++; $display("FAIL frame%0d_pulses: got %0d want 34", mode, rise_q.size()); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL frame%0d_busy_end: got %b want 0", mode, busy); end
        if (rise_q.size() == 34 && fall_q.size() == 34 && fd_q.size() == 1) begin
            want = t0 + 2 + P_AS;
            nvec++; if (rise_q[0] != want) begin nerr++; $display("FAIL frame%0d_latency: got %0d want %0d", mode, rise_q[0] - t0, want - t0); end
            for (int unsigned k = 0; k < 34; k++) begin
                e = model_frame(k);
                nvec++; if ({rs_q[k], db_q[k]} !== e) begin nerr++; $display("FAIL frame%0d_byte[%0d]: got rs=%b db=%h want rs=%b db=%h", mode, k, rs_q[k], db_q[k], e[8], e[7:0]); end
                if (e[8]) begin
                    nvec++; if (addr_q[k] !== model_frame_addr(k)) begin nerr++; $display("FAIL frame%0d_addr[%0d]: got %0d want %0d", mode, k, addr_q[k], model_frame_addr(k)); end
                end
                nvec++; if (fall_q[k] - rise_q[k] != P_PW) begin nerr++; $display("FAIL frame%0d_ewidth[%0d]: got %0d want %0d", mode, k, fall_q[k] - rise_q[k], P_PW); end
                if (k > 0) begin
                    nvec++; if (rise_q[k] - fall_q[k - 1] != model_frame_gap(k)) begin nerr++; $display("FAIL frame%0d_gap[%0d]: got %0d want %0d", mode, k, rise_q[k] - fall_q[k - 1], model_frame_gap(k)); end
                end
                // RS/DB must be settled T_AS before E rises and unchanged through the wait.
                have_before = 1'b0; have_after = 1'b0; c_before = 0; c_after = 0;
                foreach (chg_q[j]) begin
                    if (chg_q[j] <= rise_q[k]) begin have_before = 1'b1; c_before = chg_q[j]; end
                    else if (!have_after) begin have_after = 1'b1; c_after = chg_q[j]; end
                end
                nvec++; if (have_before && rise_q[k] - c_before < P_AS) begin nerr++; $display("FAIL frame%0d_setup[%0d]: got %0d want >=%0d", mode, k, rise_q[k] - c_before, P_AS); end
                nvec++; if (have_after && c_after < fall_q[k] + P_CMD) begin nerr++; $display("FAIL frame%0d_hold[%0d]: got %0d want >=%0d", mode, k, c_after - fall_q[k], P_CMD); end
            end
            nvec++; if (fd_q[0] != fall_q[33] + P_CMD) begin nerr++; $display("FAIL frame%0d_done_time: got %0d want %0d", mode, fd_q[0] - fall_q[33], P_CMD); end
            if (mode == 1) begin
                nvec++; if (db_q[6] !== 8'hF2)  begin nerr++; $display("FAIL glyph_f2: got %h want f2", db_q[6]); end
                nvec++; if (db_q[33] !== 8'h00) begin nerr++; $display("FAIL glyph_00: got %h want 00", db_q[33]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int unsigned rel, a, b, want;
        logic [8:0] e;
        rst_n = 1'b0;
        for (int unsigned i = 0; i < 32; i++) mem[i] = 8'($urandom_range(0, 255));
        repeat (2) @(posedge clk);
        release_reset(rel);
        wait_rises(2, 500);
        pulse_req();
        a = 6 + 3 + $urandom_range(0, 10);
        b = 6 + 18 + $urandom_range(0, 12);
        wait_rises(a, 2000);
        pulse_req();
        wait_rises(b, 2000);
        pulse_req();
        wait_frames(2, 5000);
        repeat (200) @(posedge clk);
        #1;
        nvec++; if (fd_q.size() != 2) begin nerr++; $display("FAIL b2b_frames: got %0d want 2", fd_q.size()); end
        nvec++; if (rise_q.size() != 74 || fall_q.size() != 74) begin nerr++; $display("FAIL b2b_pulses: got %0d want 74", rise_q.size()); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
        if (fd_q.size() == 2 && rise_q.size() == 74 && fall_q.size() == 74) begin
            want = P_CMD + 1 + P_AS;
            nvec++; if (rise_q[6] - fall_q[5] != want) begin nerr++; $display("FAIL b2b_start_gap: got %0d want %0d", rise_q[6] - fall_q[5], want); end
            nvec++; if (rise_q[40] - fall_q[39] != want) begin nerr++; $display("FAIL b2b_frame_gap: got %0d want %0d", rise_q[40] - fall_q[39], want); end
            nvec++; if (fd_q[0] != fall_q[39] + P_CMD) begin nerr++; $display("FAIL b2b_done1_time: got %0d want %0d", fd_q[0] - fall_q[39], P_CMD); end
            for (int unsigned k = 0; k < 68; k++) begin
                e = model_frame(k % 34);
                nvec++; if ({rs_q[6 + k], db_q[6 + k]} !== e) begin nerr++; $display("FAIL b2b_byte[%0d]: got rs=%b db=%h want rs=%b db=%h", k, rs_q[6 + k], db_q[6 + k], e[8], e[7:0]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int unsigned rel;
        for (int unsigned i = 0; i < 32; i++) mem[i] = 8'($urandom_range(0, 255));
        clear_logs();
        pulse_req();
        wait_rises(23, 3000);
        #1;
        nvec++; if (bus.lcd_e !== 1'b1 || db_q.size() < 23) begin nerr++; $display("FAIL rmid_in_char20: got e=%b pulses=%0d want e=1 pulses=23", bus.lcd_e, db_q.size()); end
        rst_n = 1'b0;
        #1;
        nvec++; if (bus.lcd_e !== 1'b0)   begin nerr++; $display("FAIL rmid_e: got %b want 0", bus.lcd_e); end
        nvec++; if (init_done !== 1'b0)   begin nerr++; $display("FAIL rmid_init_done: got %b want 0", init_done); end
        nvec++; if (busy !== 1'b1)        begin nerr++; $display("FAIL rmid_busy: got %b want 1", busy); end
        nvec++; if (bus.lcd_db !== 8'h00 || bus.lcd_rs !== 1'b0 || bus.rd_addr !== 5'd0) begin nerr++; $display("FAIL rmid_bus: got db=%h rs=%b addr=%0d want 00 0 0", bus.lcd_db, bus.lcd_rs, bus.rd_addr); end
        repeat (3) @(posedge clk);
        release_reset(rel);
        wait_init(2000);
        repeat (300) @(posedge clk);
        #1;
        nvec++; if (id_q.size() != 1) begin nerr++; $display("FAIL rmid_reinit: got %0d want 1", id_q.size()); end
        nvec++; if (rise_q.size() != 6) begin nerr++; $display("FAIL rmid_no_frame: got %0d pulses want 6", rise_q.size()); end
        nvec++; if (fd_q.size() != 0) begin nerr++; $display("FAIL rmid_no_done: got %0d want 0", fd_q.size()); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rmid_busy_end: got %b want 0", busy); end
        if (rise_q.size() == 6) begin
            nvec++; if (rise_q[0] != rel + P_PWR + P_AS) begin nerr++; $display("FAIL rmid_first_rise: got %0d want %0d", rise_q[0] - rel, P_PWR + P_AS); end
            for (int unsigned k = 0; k < 6; k++) begin
                nvec++; if ({rs_q[k], db_q[k]} !== {1'b0, model_init_cmd(k)}) begin nerr++; $display("FAIL rmid_cmd[%0d]: got rs=%b db=%h want rs=0 db=%h", k, rs_q[k], db_q[k], model_init_cmd(k)); end
            end
        end
    endtask

    initial begin
        for (int unsigned i = 0; i < 32; i++) mem[i] = 8'h20;
        test_reset();
        test_init();
        test_frame(0);
        test_frame(1);
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
